// File: rtl/mux8_rr_arbiter.sv
// Round-robin scheduler sharing one 8-to-1 selection path between eight requesters,
// with a single registered output slot on a valid/ready handshake.
module mux8_rr_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [7:0]         req,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [7:0]         grant,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_sel,
  output logic [CNT_W-1:0]   xfer_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [2:0]       last_ptr_q, last_ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_next;
  logic             found;
  logic             load;
  logic             xfer;

  // Search starts just after the last served requester and ends on it,
  // so a lone requester is picked again every cycle.
  always_comb begin
    sel_next = last_ptr_q;
    found    = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (!found && req[last_ptr_q + 3'(k)]) begin
        sel_next = last_ptr_q + 3'(k);
        found    = 1'b1;
      end
    end
  end

  assign load = enable && found && (state_q == EMPTY || out_ready) && !reset;
  assign xfer = (state_q == FULL) && out_ready;

  always_comb begin
    state_d    = state_q;
    last_ptr_d = last_ptr_q;
    data_d     = data_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    grant      = 8'h00;
    case (state_q)
      EMPTY:   if (load) state_d = FULL;
      FULL:    if (out_ready && !load) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (load) begin
      data_d     = in_data[32'(sel_next)*WIDTH +: WIDTH];
      sel_d      = sel_next;
      last_ptr_d = sel_next;
      grant      = 8'b1 << sel_next;
    end
    if (xfer) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      last_ptr_q <= 3'd7;
      data_q     <= '0;
      sel_q      <= 3'd0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_ptr_q <= last_ptr_d;
      data_q     <= data_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid  = (state_q == FULL);
  assign out_data   = data_q;
  assign out_sel    = sel_q;
  assign xfer_count = cnt_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: a per-cycle reference model plus hand-computed checkpoints.
module tb_mux8_rr_arbiter;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic [7:0]         req;
  logic [8*WIDTH-1:0] in_data;
  logic [7:0]         grant;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [2:0]         out_sel;
  logic [CNT_W-1:0]   xfer_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit run_cmp = 1'b0;

  // Reference model state
  int          m_last;
  bit          m_valid;
  logic [31:0] m_data;
  int          m_sel;
  int          m_cnt;

  mux8_rr_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .req(req), .in_data(in_data),
    .grant(grant), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  function automatic int pick(input int last, input logic [7:0] r);
    for (int k = 1; k <= 8; k++)
      if (r[(last + k) % 8]) return (last + k) % 8;
    return -1;
  endfunction

  function automatic bit model_load();
    return !reset && enable && (req != 8'h00) && (!m_valid || out_ready);
  endfunction

  function automatic logic [7:0] model_grant();
    logic [7:0] g;
    g = 8'h00;
    if (model_load()) g[pick(m_last, req)] = 1'b1;
    return g;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_last <= 7; m_valid <= 1'b0; m_data <= '0; m_sel <= 0; m_cnt <= 0;
    end else begin
      int s;
      s = pick(m_last, req);
      if (m_valid && out_ready) m_cnt <= (m_cnt + 1) % (1 << CNT_W);
      if (model_load()) begin
        m_data  <= in_data[s*WIDTH +: WIDTH];
        m_sel   <= s;
        m_last  <= s;
        m_valid <= 1'b1;
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("m_grant", 32'(grant), 32'(model_grant()));
      chk("m_valid", 32'(out_valid), 32'(m_valid));
      chk("m_sel", 32'(out_sel), 32'(m_sel));
      chk("m_data", out_data, m_data);
      chk("m_count", 32'(xfer_count), 32'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    reset = 1'b1; enable = 1'b0; req = 8'h00; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) in_data[i*WIDTH +: WIDTH] = 32'h1000_0000 + i;
    step(); step();
    reset = 1'b0;
    run_cmp = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_count", 32'(xfer_count), 32'h0);
    chk("rst_data", out_data, 32'h0);

    // Fairness: full rotation starting at requester 0
    enable = 1'b1; req = 8'hFF; out_ready = 1'b1;
    #1;
    for (int i = 0; i <= 8; i++) begin
      chk("fair_grant", 32'(grant), 32'(8'b1 << (i % 8)));
      step();
      chk("fair_data", out_data, 32'h1000_0000 + (i % 8));
      chk("fair_sel", 32'(out_sel), 32'(i % 8));
    end
    chk("fair_count", 32'(xfer_count), 32'd8);
    req = 8'h00;
    step();
    chk("fair_drain", 32'(out_valid), 32'h0);

    // Wrap skip: park the pointer on 5, then search 6,7,0
    req = 8'h20;
    step();
    req = 8'b0010_0001;
    #1;
    chk("wrap_g0", 32'(grant), 32'h01);
    step();
    chk("wrap_sel0", 32'(out_sel), 32'd0);
    chk("wrap_g1", 32'(grant), 32'h20);
    step();
    chk("wrap_sel1", 32'(out_sel), 32'd5);
    req = 8'h00;
    step();

    // Backpressure on a captured requester 3
    in_data[3*WIDTH +: WIDTH] = 32'hA5A5_A5A5;
    req = 8'h08;
    step();
    chk("bp_cap", out_data, 32'hA5A5_A5A5);
    out_ready = 1'b0; req = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_grant", 32'(grant), 32'h00);
      step();
      chk("bp_data", out_data, 32'hA5A5_A5A5);
      chk("bp_sel", 32'(out_sel), 32'd3);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release", 32'(grant), 32'h10);
    step();
    chk("bp_next", 32'(out_sel), 32'd4);
    req = 8'h00;
    step();

    // Enable gating with a held word
    req = 8'h08; out_ready = 1'b0;
    step();
    enable = 1'b0; req = 8'h04;
    #1;
    chk("en_g0", 32'(grant), 32'h00);
    step();
    chk("en_hold", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    #1;
    chk("en_g1", 32'(grant), 32'h00);
    step();
    chk("en_drop", 32'(out_valid), 32'h0);
    chk("en_g2", 32'(grant), 32'h00);
    enable = 1'b1;
    #1;
    chk("en_on", 32'(grant), 32'h04);
    step();
    chk("en_valid", 32'(out_valid), 32'h1);
    chk("en_sel", 32'(out_sel), 32'd2);
    req = 8'h00;
    step();

    // Counter wrap: 17 handshakes on a 4-bit counter
    c0 = m_cnt;
    req = 8'h01;
    for (int i = 0; i < 17; i++) step();
    req = 8'h00;
    step();
    chk("cnt_wrap", 32'(xfer_count), 32'((c0 + 1) % 16));
    for (int i = 0; i < 3; i++) step();
    chk("cnt_idle", 32'(xfer_count), 32'((c0 + 1) % 16));

    // Asynchronous reset while FULL
    in_data[0 +: WIDTH] = 32'hDEAD_BEEF;
    req = 8'h01; out_ready = 1'b0;
    step();
    chk("ar_cap", out_data, 32'hDEAD_BEEF);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 32'h0);
    chk("ar_data", out_data, 32'h0);
    chk("ar_count", 32'(xfer_count), 32'h0);
    chk("ar_grant", 32'(grant), 32'h00);
    step();
    reset = 1'b0; req = 8'hFF; out_ready = 1'b1;
    #1;
    chk("ar_first", 32'(grant), 32'h01);
    step();
    chk("ar_sel", 32'(out_sel), 32'd0);
    step();

    run_cmp = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
